// File: rtl/riscv_pkg.sv
// Shared types for the decode-side hazard logic: scoreboard entry layout,
// operand-forwarding select encoding and the in-flight depth.
package riscv_pkg;

    localparam int NUM_STAGES = 3;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    // x0 is hardwired to zero, so a writer of x0 can never supply an operand.
    function automatic logic sb_match(sb_entry_t entry, logic [4:0] src, logic use_src);
        return entry.valid && (entry.rd != 5'd0) && (entry.rd == src) && use_src;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select: finds the youngest in-flight producer of one
// source register and flags a load in EX that cannot forward yet.
module hazard_fwd_sel
    import riscv_pkg::*;
(
    input  logic                         [4:0] src,
    input  logic                               use_src,
    input  sb_entry_t [NUM_STAGES-1:0]         sb,
    output fwd_sel_t                           fwd_sel,
    output logic                               load_use
);

    logic match_ex;
    logic match_mem;
    logic match_wb;
    logic unused_is_load;

    assign match_ex  = sb_match(sb[0], src, use_src);
    assign match_mem = sb_match(sb[1], src, use_src);
    assign match_wb  = sb_match(sb[2], src, use_src);

    // Only the EX entry's load flag matters; older loads already have data.
    assign unused_is_load = sb[1].is_load ^ sb[2].is_load;

    always_comb begin
        fwd_sel  = FWD_RF;
        load_use = match_ex && sb[0].is_load;
        if (match_ex && !sb[0].is_load) begin
            fwd_sel = FWD_EX;
        end else if (match_mem) begin
            fwd_sel = FWD_MEM;
        end else if (match_wb) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller beside decode: tracks in-flight destinations,
// drives stall/flush/forward selects and counts load-use stall cycles.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_wr_en_i,
    input  logic             id_is_load_i,
    input  logic             branch_taken_i,
    input  logic             mem_wait_i,
    output logic             stall_o,
    output logic             flush_id_o,
    output logic             flush_if_o,
    output logic [1:0]       fwd_rs1_o,
    output logic [1:0]       fwd_rs2_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    sb_entry_t [NUM_STAGES-1:0] sb_q;
    logic [CNT_W-1:0]           stall_cnt_q;

    fwd_sel_t fwd_rs1;
    fwd_sel_t fwd_rs2;
    logic     lu_rs1;
    logic     lu_rs2;
    logic     load_use_hz;
    logic     insert_bubble;
    logic     advance;

    hazard_fwd_sel u_fwd_rs1 (
        .src      (id_rs1_i),
        .use_src  (id_use_rs1_i),
        .sb       (sb_q),
        .fwd_sel  (fwd_rs1),
        .load_use (lu_rs1)
    );

    hazard_fwd_sel u_fwd_rs2 (
        .src      (id_rs2_i),
        .use_src  (id_use_rs2_i),
        .sb       (sb_q),
        .fwd_sel  (fwd_rs2),
        .load_use (lu_rs2)
    );

    assign load_use_hz   = id_valid_i && (lu_rs1 || lu_rs2);
    assign advance       = !mem_wait_i;
    // A taken branch makes the decode instruction wrong-path, so it wins over load-use.
    assign insert_bubble = branch_taken_i || load_use_hz;

    always_comb begin
        stall_o    = 1'b0;
        flush_id_o = 1'b0;
        flush_if_o = 1'b0;
        fwd_rs1_o  = FWD_RF;
        fwd_rs2_o  = FWD_RF;
        if (rst_n) begin
            fwd_rs1_o = fwd_rs1;
            fwd_rs2_o = fwd_rs2;
            if (mem_wait_i) begin
                stall_o = 1'b1;
            end else if (branch_taken_i) begin
                flush_if_o = 1'b1;
                flush_id_o = 1'b1;
            end else if (load_use_hz) begin
                stall_o    = 1'b1;
                flush_id_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else if (advance) begin
            for (int k = NUM_STAGES - 1; k > 0; k--) begin
                sb_q[k] <= sb_q[k-1];
            end
            if (insert_bubble) begin
                sb_q[0] <= '0;
            end else begin
                sb_q[0] <= '{valid: id_valid_i && id_wr_en_i, rd: id_rd_i, is_load: id_is_load_i};
            end
            if (!branch_taken_i && load_use_hz && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_hazard_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid_i = 1'b0;
    logic [4:0]    id_rs1_i = '0;
    logic [4:0]    id_rs2_i = '0;
    logic          id_use_rs1_i = 1'b0;
    logic          id_use_rs2_i = 1'b0;
    logic [4:0]    id_rd_i = '0;
    logic          id_wr_en_i = 1'b0;
    logic          id_is_load_i = 1'b0;
    logic          branch_taken_i = 1'b0;
    logic          mem_wait_i = 1'b0;
    logic          stall_o;
    logic          flush_id_o;
    logic          flush_if_o;
    logic [1:0]    fwd_rs1_o;
    logic [1:0]    fwd_rs2_o;
    logic [CW-1:0] stall_cnt_o;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_use_rs1_i   (id_use_rs1_i),
        .id_use_rs2_i   (id_use_rs2_i),
        .id_rd_i        (id_rd_i),
        .id_wr_en_i     (id_wr_en_i),
        .id_is_load_i   (id_is_load_i),
        .branch_taken_i (branch_taken_i),
        .mem_wait_i     (mem_wait_i),
        .stall_o        (stall_o),
        .flush_id_o     (flush_id_o),
        .flush_if_o     (flush_if_o),
        .fwd_rs1_o      (fwd_rs1_o),
        .fwd_rs2_o      (fwd_rs2_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight writers ordered by age (index 0 = just issued into EX).
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       ld;
    } inst_t;

    inst_t inflight[$];
    int    m_cnt;

    function automatic int m_fwd(bit [4:0] src, bit use_src);
        for (int age = 0; age < inflight.size(); age++) begin
            if (use_src && inflight[age].v && inflight[age].rd != 0 && inflight[age].rd == src) begin
                if (age == 0 && inflight[age].ld) continue;
                return age + 1;
            end
        end
        return 0;
    endfunction

    function automatic bit m_lu();
        inst_t ex;
        ex = inflight[0];
        if (!id_valid_i || !ex.v || !ex.ld || ex.rd == 0) return 1'b0;
        return (id_use_rs1_i && ex.rd == id_rs1_i) || (id_use_rs2_i && ex.rd == id_rs2_i);
    endfunction

    task automatic m_clear();
        inst_t b;
        b = '{v: 1'b0, rd: 5'd0, ld: 1'b0};
        inflight = {b, b, b};
        m_cnt = 0;
    endtask

    initial m_clear();

    always @(posedge clk or negedge rst_n) begin : model_update
        bit    lu;
        inst_t n;
        if (!rst_n) begin
            m_clear();
        end else if (!mem_wait_i) begin
            lu = m_lu();
            if (branch_taken_i || lu) n = '{v: 1'b0, rd: 5'd0, ld: 1'b0};
            else n = '{v: id_valid_i && id_wr_en_i, rd: id_rd_i, ld: id_is_load_i};
            inflight.push_front(n);
            void'(inflight.pop_back());
            if (!branch_taken_i && lu && m_cnt < CMAX) m_cnt++;
        end
    end

    always @(negedge clk) begin : compare
        int e_stall, e_fid, e_fif, e_f1, e_f2, e_cnt;
        bit lu;
        e_stall = 0; e_fid = 0; e_fif = 0; e_f1 = 0; e_f2 = 0; e_cnt = 0;
        if (rst_n) begin
            lu    = m_lu();
            e_f1  = m_fwd(id_rs1_i, id_use_rs1_i);
            e_f2  = m_fwd(id_rs2_i, id_use_rs2_i);
            e_cnt = m_cnt;
            if (mem_wait_i) e_stall = 1;
            else if (branch_taken_i) begin e_fif = 1; e_fid = 1; end
            else if (lu) begin e_stall = 1; e_fid = 1; end
        end
        chk("model_stall", stall_o, e_stall);
        chk("model_flush_id", flush_id_o, e_fid);
        chk("model_flush_if", flush_if_o, e_fif);
        chk("model_fwd_rs1", fwd_rs1_o, e_f1);
        chk("model_fwd_rs2", fwd_rs2_o, e_f2);
        chk("model_stall_cnt", stall_cnt_o, e_cnt);
    end

    task automatic step(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                        input bit u2, input bit [4:0] rd, input bit wr, input bit ld,
                        input bit br, input bit mw);
        @(posedge clk); #1;
        id_valid_i = v; id_rs1_i = r1; id_use_rs1_i = u1; id_rs2_i = r2; id_use_rs2_i = u2;
        id_rd_i = rd; id_wr_en_i = wr; id_is_load_i = ld; branch_taken_i = br; mem_wait_i = mw;
        @(negedge clk); #1;
    endtask

    initial begin
        @(negedge clk); #1;
        chk("reset_stall", stall_o, 0);
        chk("reset_fwd_rs1", fwd_rs1_o, 0);
        chk("reset_cnt", stall_cnt_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ALU back-to-back
        step(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        chk("first_after_reset_fwd", fwd_rs1_o, 0);
        chk("first_after_reset_stall", stall_o, 0);
        step(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
        chk("alu_b2b_rs1", fwd_rs1_o, 1);
        chk("alu_b2b_rs2", fwd_rs2_o, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_wb_rs1", fwd_rs1_o, 3);

        // Load-use
        step(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
        step(1, 7, 1, 1, 1, 8, 1, 0, 0, 0);
        chk("lu_stall", stall_o, 1);
        chk("lu_flush_id", flush_id_o, 1);
        chk("lu_flush_if", flush_if_o, 0);
        chk("lu_cnt_before", stall_cnt_o, 0);
        step(1, 7, 1, 1, 1, 8, 1, 0, 0, 0);
        chk("lu_after_stall", stall_o, 0);
        chk("lu_after_fwd_rs1", fwd_rs1_o, 2);
        chk("lu_after_fwd_rs2", fwd_rs2_o, 0);
        chk("lu_cnt_after", stall_cnt_o, 1);

        // x0 writer never matches
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        chk("x0_stall", stall_o, 0);
        chk("x0_fwd_rs1", fwd_rs1_o, 0);
        chk("x0_fwd_rs2", fwd_rs2_o, 0);

        // Branch in the same cycle as a load-use match
        step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
        step(1, 9, 1, 0, 0, 3, 1, 0, 1, 0);
        chk("br_flush_if", flush_if_o, 1);
        chk("br_flush_id", flush_id_o, 1);
        chk("br_stall", stall_o, 0);
        chk("br_cnt", stall_cnt_o, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_cnt_next", stall_cnt_o, 1);

        // Memory wait with a load in EX
        step(1, 0, 0, 0, 0, 10, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 10, 1, 0, 0, 11, 1, 0, 0, 1);
            chk("mw_stall", stall_o, 1);
            chk("mw_flush_id", flush_id_o, 0);
            chk("mw_fwd_rs1", fwd_rs1_o, 0);
            chk("mw_cnt", stall_cnt_o, 1);
        end
        step(1, 10, 1, 0, 0, 11, 1, 0, 0, 0);
        chk("mw_release_stall", stall_o, 1);
        chk("mw_release_flush_id", flush_id_o, 1);
        step(1, 10, 1, 0, 0, 11, 1, 0, 0, 0);
        chk("mw_after_fwd_rs1", fwd_rs1_o, 2);
        chk("mw_after_cnt", stall_cnt_o, 2);

        // Reset mid-stream while WB would otherwise forward x10
        step(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("midrst_fwd_rs1", fwd_rs1_o, 0);
        chk("midrst_stall", stall_o, 0);
        chk("midrst_cnt", stall_cnt_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        id_valid_i = 1'b1; id_rs1_i = 5'd10; id_use_rs1_i = 1'b1; id_rs2_i = 5'd10;
        id_use_rs2_i = 1'b1; id_rd_i = 5'd12; id_wr_en_i = 1'b1; id_is_load_i = 1'b0;
        @(negedge clk); #1;
        chk("postrst_fwd_rs1", fwd_rs1_o, 0);
        chk("postrst_fwd_rs2", fwd_rs2_o, 0);
        chk("postrst_stall", stall_o, 0);

        // Randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst_n          = ($urandom_range(0, 1499) != 0);
            id_valid_i     = ($urandom_range(0, 9) != 0);
            id_rs1_i       = 5'($urandom_range(0, 7));
            id_rs2_i       = 5'($urandom_range(0, 7));
            id_use_rs1_i   = ($urandom_range(0, 4) != 0);
            id_use_rs2_i   = ($urandom_range(0, 2) != 0);
            id_rd_i        = 5'($urandom_range(0, 7));
            id_wr_en_i     = ($urandom_range(0, 4) != 0);
            id_is_load_i   = ($urandom_range(0, 2) == 0);
            branch_taken_i = ($urandom_range(0, 11) == 0);
            mem_wait_i     = ($urandom_range(0, 6) == 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
